reaction_timer_ctrl: RTL
========================

Name: reaction_timer_ctrl

Overview:
Top-level sequencer for the reaction timer.
- Waits a pseudo-random delay, lights the stimulus LED, then enables and clears the external n-digit BCD millisecond counter.
- Captures the counter value when the player reacts and keeps a best (lowest) time.
- Detects false starts and timeouts.
- Sits between the debounced button pulses / 1 ms tick generator and the BCD counter and display.

Parameters:
- DIGITS, 4, number of BCD digits on count_in, result and best_time.
- MIN_DELAY_MS, 1000, fixed part of the random wait, in ms ticks.
- RAND_BITS, 11, width of the random addend; wait = MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
- LFSR_SEED, 16'hACE1, nonzero reset value of the internal 16-bit LFSR.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_btn  in  1  one-cycle pulse; starts a trial.
- react_btn  in  1  one-cycle pulse; player response.
- ms_tick  in  1  one-cycle pulse every 1 ms.
- clear_best  in  1  one-cycle pulse; invalidates best_time.
- count_in  in  4*DIGITS  current BCD counter value.
- cnt_clr  out  1  synchronous clear to the BCD counter.
- cnt_en  out  1  count enable to the BCD counter.
- led  out  1  stimulus LED.
- done  out  1  valid result held.
- false_start  out  1  react pressed before stimulus.
- timeout  out  1  no reaction before the counter saturated.
- result  out  4*DIGITS  captured reaction time, BCD.
- best_time  out  4*DIGITS  lowest valid result, BCD.
- best_valid  out  1  best_time holds a real value.

Behaviour:
- Reset (asynchronous): state=IDLE; LFSR=LFSR_SEED; delay counter=0; all outputs 0, including result, best_time and best_valid.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk in every state. Never reaches zero.
- Delay counter width: ceil(log2(MIN_DELAY_MS + 2^RAND_BITS)) + 1 bits.
- States: IDLE, ARM, WAIT, STIM, RESULT, FALSE_ST, TMOUT. All outputs are registered; each flag is high exactly while its state is occupied.
- IDLE: on start_btn -> ARM.
- ARM (exactly 1 cycle):
  - delay <= MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
  - cnt_clr=1 during this cycle; result is unchanged.
  - Always -> WAIT.
- WAIT: led=0, cnt_en=0.
  - On ms_tick, delay decrements.
  - On ms_tick with delay==1 -> STIM. Exactly delay ticks elapse.
  - react_btn -> FALSE_ST. If react_btn coincides with the final ms_tick, react wins (FALSE_ST).
  - start_btn is ignored.
- STIM: led=1; cnt_en = ms_tick, combinationally gated by state.
  - react_btn -> RESULT, result <= count_in. cnt_en is forced to 0 in that cycle, even if ms_tick=1.
  - Else if count_in equals all-9s (16'h9999 for DIGITS=4) -> TMOUT, result <= count_in.
  - react has priority over timeout in the same cycle.
  - start_btn is ignored.
- RESULT: done=1, led=0.
  - On entry, best is updated if best_valid==0 or result < best_time. Straight unsigned compare is valid for legal BCD. The update then sets best_valid=1.
  - start_btn -> ARM.
- FALSE_ST: false_start=1; result is not updated; start_btn -> ARM.
- TMOUT: timeout=1; best is never updated from a timeout; start_btn -> ARM.
- clear_best: in any state, next cycle best_valid=0 and best_time=0.
  - If a best update happens in the same cycle, clear wins.
- Buttons pulsed in states where they are not listed are ignored. No queuing.
- rst asserted mid-trial returns to IDLE immediately with led=0 and cnt_en=0.

Test Plan:
- Params MIN_DELAY_MS=10, RAND_BITS=2, seed 16'hACE1; start_btn, then ms_tick every 8 clk:
  - ARM lasts 1 cycle with cnt_clr=1.
  - led rises exactly (10 + lfsr[1:0] at ARM) ticks later.
  - The reference model computes the LFSR value.
- During STIM, drive count_in=16'h0237 and pulse react_btn -> result=16'h0237, done=1, best_time=16'h0237, best_valid=1. A second trial with 16'h0150 -> best_time=16'h0150. A third with 16'h0300 -> best_time stays 16'h0150.
- react_btn pulsed 3 ticks into WAIT -> false_start=1, led never rises, result and best unchanged. start_btn then restarts via ARM.
- In STIM, hold count_in=16'h9999 -> TMOUT next cycle, timeout=1, best unchanged.
- react_btn and ms_tick in the same STIM cycle -> cnt_en=0 that cycle, RESULT entered. react_btn on the final WAIT tick -> FALSE_ST.
- Mid-STIM rst pulse -> all outputs 0 asynchronously, state IDLE, LFSR=16'hACE1. clear_best together with a best update -> best_valid=0.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer_ctrl
// Description : Top-level sequencer for the reaction timer. It waits a
//               pseudo-random number of millisecond ticks, lights the
//               stimulus LED, and enables and clears the external BCD
//               millisecond counter. It captures the counter value when the
//               player reacts and keeps the best (lowest) time. It also
//               detects false starts and timeouts.
//
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               start_btn         - one-cycle pulse, starts a trial
//               react_btn         - one-cycle pulse, player response
//               ms_tick           - one-cycle pulse every millisecond
//               clear_best        - one-cycle pulse, invalidates best_time
//               count_in          - current BCD counter value
//               cnt_clr, cnt_en   - clear / enable to the BCD counter
//               led               - stimulus LED
//               done, false_start,
//               timeout           - trial outcome flags
//               result            - captured reaction time (BCD)
//               best_time,
//               best_valid        - lowest valid result and its valid flag
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer_ctrl #(
    parameter int          DIGITS       = 4,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_btn,
    input  logic                react_btn,
    input  logic                ms_tick,
    input  logic                clear_best,
    input  logic [4*DIGITS-1:0] count_in,
    output logic                cnt_clr,
    output logic                cnt_en,
    output logic                led,
    output logic                done,
    output logic                false_start,
    output logic                timeout,
    output logic [4*DIGITS-1:0] result,
    output logic [4*DIGITS-1:0] best_time,
    output logic                best_valid
);

    localparam int c_CNT_W = 4 * DIGITS;
    // One spare bit above the largest loadable delay value.
    localparam int c_DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;

    localparam logic [c_CNT_W-1:0] c_ALL_NINES = {DIGITS{4'h9}};
    localparam logic [c_DLY_W-1:0] c_MIN_DELAY = c_DLY_W'(MIN_DELAY_MS);
    localparam logic [c_DLY_W-1:0] c_DLY_ONE   = c_DLY_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT     = 3'd2,
        S_STIM     = 3'd3,
        S_RESULT   = 3'd4,
        S_FALSE_ST = 3'd5,
        S_TMOUT    = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_lfsr;
    logic                 w_lfsr_fb;
    logic [c_DLY_W-1:0]   r_delay;
    logic [c_DLY_W-1:0]   w_delay_nxt;
    logic [c_CNT_W-1:0]   r_result;
    logic [c_CNT_W-1:0]   w_result_nxt;
    logic [c_CNT_W-1:0]   r_best;
    logic [c_CNT_W-1:0]   w_best_nxt;
    logic                 r_best_valid;
    logic                 w_best_valid_nxt;
    logic                 r_cnt_clr;
    logic                 r_led;
    logic                 r_done;
    logic                 r_false_start;
    logic                 r_timeout;

    // Fibonacci LFSR, taps 16,14,13,11. A nonzero seed keeps it off the
    // all-zero lock-up state.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_lfsr        <= LFSR_SEED;
            r_delay       <= '0;
            r_result      <= '0;
            r_best        <= '0;
            r_best_valid  <= 1'b0;
            r_cnt_clr     <= 1'b0;
            r_led         <= 1'b0;
            r_done        <= 1'b0;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lfsr        <= {r_lfsr[14:0], w_lfsr_fb};
            r_delay       <= w_delay_nxt;
            r_result      <= w_result_nxt;
            r_best        <= w_best_nxt;
            r_best_valid  <= w_best_valid_nxt;
            // Flags are decoded from the next state so that each one is a
            // flop that is high exactly while its state is occupied.
            r_cnt_clr     <= (w_state_nxt == S_ARM);
            r_led         <= (w_state_nxt == S_STIM);
            r_done        <= (w_state_nxt == S_RESULT);
            r_false_start <= (w_state_nxt == S_FALSE_ST);
            r_timeout     <= (w_state_nxt == S_TMOUT);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_delay_nxt      = r_delay;
        w_result_nxt     = r_result;
        w_best_nxt       = r_best;
        w_best_valid_nxt = r_best_valid;

        case (r_state)
            S_IDLE: begin
                if (start_btn) begin
                    w_state_nxt = S_ARM;
                end
            end

            S_ARM: begin
                w_delay_nxt = c_MIN_DELAY + c_DLY_W'(r_lfsr[RAND_BITS-1:0]);
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                // A reaction on the final tick still counts as a false start.
                if (react_btn) begin
                    w_state_nxt = S_FALSE_ST;
                end else if (ms_tick) begin
                    if (r_delay <= c_DLY_ONE) begin
                        w_delay_nxt = '0;
                        w_state_nxt = S_STIM;
                    end else begin
                        w_delay_nxt = r_delay - c_DLY_ONE;
                    end
                end
            end

            S_STIM: begin
                if (react_btn) begin
                    w_state_nxt  = S_RESULT;
                    w_result_nxt = count_in;
                    // Legal BCD orders the same as plain binary.
                    if (!r_best_valid || (count_in < r_best)) begin
                        w_best_nxt       = count_in;
                        w_best_valid_nxt = 1'b1;
                    end
                end else if (count_in == c_ALL_NINES) begin
                    w_state_nxt  = S_TMOUT;
                    w_result_nxt = count_in;
                end
            end

            S_RESULT, S_FALSE_ST, S_TMOUT: begin
                if (start_btn) begin
                    w_state_nxt = S_ARM;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Clearing the best time overrides an update in the same cycle.
        if (clear_best) begin
            w_best_nxt       = '0;
            w_best_valid_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The counter enable follows the tick directly while stimulus is lit,
    // and is suppressed in the reaction cycle so the captured value is final.
    assign cnt_en      = r_led & ms_tick & ~react_btn;
    assign cnt_clr     = r_cnt_clr;
    assign led         = r_led;
    assign done        = r_done;
    assign false_start = r_false_start;
    assign timeout     = r_timeout;
    assign result      = r_result;
    assign best_time   = r_best;
    assign best_valid  = r_best_valid;

endmodule
`default_nettype wire
